// File: rtl/alu16_cla.sv
// alu16_cla: 16-bit registered ALU with the 74181 function set, four 4-bit slices joined by 74182-style lookahead.
// Latency: 1 cycle; operands captured on a rising clk edge appear on the outputs right after that edge.
// Backpressure: none; a new operation is accepted on every cycle and the previous result is overwritten.
module alu16_cla (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        Cin,
    input  logic        mode,
    input  logic [3:0]  sel,
    output logic [15:0] result,
    output logic        Cout,
    output logic        nBo,
    output logic        nGo
);
    // Subtract select: its carry-out is reported as an active-low borrow,
    // so the polarity of Cout flips for this one arithmetic function.
    localparam logic [3:0] SEL_SUB = 4'b0110;

    // Per-bit function terms and their generate/propagate.
    logic [15:0] w_u;
    logic [15:0] w_v;
    logic [15:0] w_g;
    logic [15:0] w_p;

    // Slice-level group terms and the carry entering each slice.
    logic [3:0]  w_slice_g;
    logic [3:0]  w_slice_p;
    logic [3:0]  w_slice_cin;

    // Whole-word lookahead results.
    logic        w_c0;
    logic        w_c4;
    logic        w_c8;
    logic        w_c12;
    logic        w_c16;
    logic        w_grp_g;
    logic        w_grp_p;

    // Next-state values for the output registers.
    logic [15:0] w_f;
    logic        w_cout_n;

    // Output registers.
    logic [15:0] r_result;
    logic        r_cout;
    logic        r_nbo;
    logic        r_ngo;

    // Carry-in pin is active-low.
    assign w_c0 = ~Cin;

    // The select lines steer which of B / ~B feeds U and V; A is always present.
    assign w_u = a | (b & {16{sel[0]}}) | (~b & {16{sel[1]}});
    assign w_v = (a & b & {16{sel[3]}}) | (a & ~b & {16{sel[2]}});

    assign w_g = w_u & w_v;
    assign w_p = w_u | w_v;

    // Four identical 4-bit slices. Each resolves its own internal carries by
    // lookahead from the slice carry-in, and exports group G/P upward.
    genvar k;
    generate
        for (k = 0; k < 4; k++) begin : g_slice
            logic [3:0] w_sg;
            logic [3:0] w_sp;
            logic [3:0] w_sc;
            logic [3:0] w_sum_c;

            assign w_sg = w_g[4*k +: 4];
            assign w_sp = w_p[4*k +: 4];

            // Internal carries, fully expanded so no carry ripples through a slice.
            assign w_sc[0] = w_slice_cin[k];
            assign w_sc[1] = w_sg[0]
                           | (w_sp[0] & w_slice_cin[k]);
            assign w_sc[2] = w_sg[1]
                           | (w_sp[1] & w_sg[0])
                           | (w_sp[1] & w_sp[0] & w_slice_cin[k]);
            assign w_sc[3] = w_sg[2]
                           | (w_sp[2] & w_sg[1])
                           | (w_sp[2] & w_sp[1] & w_sg[0])
                           | (w_sp[2] & w_sp[1] & w_sp[0] & w_slice_cin[k]);

            // Slice group generate/propagate, independent of the carry-in.
            assign w_slice_g[k] = w_sg[3]
                                | (w_sp[3] & w_sg[2])
                                | (w_sp[3] & w_sp[2] & w_sg[1])
                                | (w_sp[3] & w_sp[2] & w_sp[1] & w_sg[0]);
            assign w_slice_p[k] = &w_sp;

            // Logic mode forces every bit carry high, which turns the sum
            // U ^ V ^ c into the XNOR of U and V -- the same trick the 74181 uses.
            assign w_sum_c = w_sc | {4{mode}};
            assign w_f[4*k +: 4] = w_u[4*k +: 4] ^ w_v[4*k +: 4] ^ w_sum_c;
        end
    endgenerate

    // Lookahead across slices, in the 74182 arrangement.
    assign w_c4  = w_slice_g[0]
                 | (w_slice_p[0] & w_c0);
    assign w_c8  = w_slice_g[1]
                 | (w_slice_p[1] & w_slice_g[0])
                 | (w_slice_p[1] & w_slice_p[0] & w_c0);
    assign w_c12 = w_slice_g[2]
                 | (w_slice_p[2] & w_slice_g[1])
                 | (w_slice_p[2] & w_slice_p[1] & w_slice_g[0])
                 | (w_slice_p[2] & w_slice_p[1] & w_slice_p[0] & w_c0);

    assign w_grp_g = w_slice_g[3]
                   | (w_slice_p[3] & w_slice_g[2])
                   | (w_slice_p[3] & w_slice_p[2] & w_slice_g[1])
                   | (w_slice_p[3] & w_slice_p[2] & w_slice_p[1] & w_slice_g[0]);
    assign w_grp_p = &w_slice_p;

    // Word carry-out falls out of the group terms without another level of logic.
    assign w_c16 = w_grp_g | (w_grp_p & w_c0);

    assign w_slice_cin = {w_c12, w_c8, w_c4, w_c0};

    // Active-low carry-out: held high in logic mode, borrow polarity for subtract.
    always_comb begin
        w_cout_n = 1'b1;
        if (!mode) begin
            if (sel == SEL_SUB) begin
                w_cout_n = w_c16;
            end else begin
                w_cout_n = ~w_c16;
            end
        end
    end

    // Output register; reset wins over any operation presented in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_result <= 16'h0000;
            r_cout   <= 1'b1;
            r_nbo    <= 1'b1;
            r_ngo    <= 1'b1;
        end else begin
            r_result <= w_f;
            r_cout   <= w_cout_n;
            r_nbo    <= ~w_grp_p;
            r_ngo    <= ~w_grp_g;
        end
    end

    assign result = r_result;
    assign Cout   = r_cout;
    assign nBo    = r_nbo;
    assign nGo    = r_ngo;

endmodule

// File: tb/tb_alu16_cla.sv
// Testbench for alu16_cla: directed vectors plus randomized operations, scoreboard-checked.
// Expected responses come from a word-level arithmetic model, one cycle behind stimulus.
// Driver and monitor are separate processes linked only by the expectation queue.
module tb_alu16_cla;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] a;
    logic [15:0] b;
    logic        Cin;
    logic        mode;
    logic [3:0]  sel;
    logic [15:0] result;
    logic        Cout;
    logic        nBo;
    logic        nGo;

    always #5 clk = ~clk;

    alu16_cla dut (
        .clk    (clk),
        .rst    (rst),
        .a      (a),
        .b      (b),
        .Cin    (Cin),
        .mode   (mode),
        .sel    (sel),
        .result (result),
        .Cout   (Cout),
        .nBo    (nBo),
        .nGo    (nGo)
    );

    typedef struct packed {
        logic [15:0] res;
        logic        cout;
        logic        nbo;
        logic        ngo;
    } exp_t;

    typedef struct {
        logic        m;
        logic [3:0]  s;
        logic [15:0] a;
        logic [15:0] b;
        logic        ci;
        logic [15:0] res;
        logic        cout;
    } dv_t;

    exp_t  sb_q[$];
    string tag_q[$];
    int    checks   = 0;
    int    failures = 0;
    dv_t   dv[17];

    // Word-level reference: plain 17-bit addition of the U and V operands.
    function automatic exp_t model(input logic r, input logic m, input logic [3:0] s,
                                   input logic [15:0] aa, input logic [15:0] bb,
                                   input logic ci);
        exp_t        e;
        logic [15:0] u;
        logic [15:0] v;
        logic [16:0] sum;
        logic [16:0] gsum;
        u    = aa | (bb & {16{s[0]}}) | (~bb & {16{s[1]}});
        v    = (aa & bb & {16{s[3]}}) | (aa & ~bb & {16{s[2]}});
        sum  = {1'b0, u} + {1'b0, v} + {16'h0000, ~ci};
        gsum = {1'b0, u} + {1'b0, v};
        if (m) begin
            e.res  = ~(u ^ v);
            e.cout = 1'b1;
        end else begin
            e.res  = sum[15:0];
            e.cout = (s == 4'b0110) ? sum[16] : ~sum[16];
        end
        e.nbo = ~(&(u | v));
        e.ngo = ~gsum[16];
        if (r) begin
            e = '{res: 16'h0000, cout: 1'b1, nbo: 1'b1, ngo: 1'b1};
        end
        return e;
    endfunction

    task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Present one operation at the falling edge and queue what should come out.
    task automatic drive(input logic r, input logic m, input logic [3:0] s,
                         input logic [15:0] aa, input logic [15:0] bb, input logic ci,
                         input bit use_k, input logic [15:0] kres, input logic kcout,
                         input string tag);
        exp_t e;
        @(negedge clk);
        rst  = r;
        mode = m;
        sel  = s;
        a    = aa;
        b    = bb;
        Cin  = ci;
        e = model(r, m, s, aa, bb, ci);
        if (use_k) begin
            e.res  = kres;
            e.cout = kcout;
        end
        sb_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic drive_rand(input logic r, input string tag);
        drive(r, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
              16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
              1'b0, 16'h0000, 1'b0, tag);
    endtask

    // Monitor: one registered response per cycle, checked against the queue head.
    initial begin
        exp_t  e;
        string t;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                t = tag_q.pop_front();
                cmp({t, ".result"}, result, e.res);
                cmp({t, ".Cout"}, {15'h0, Cout}, {15'h0, e.cout});
                cmp({t, ".nBo"}, {15'h0, nBo}, {15'h0, e.nbo});
                cmp({t, ".nGo"}, {15'h0, nGo}, {15'h0, e.ngo});
            end
        end
    end

    // Stimulus.
    initial begin
        rst  = 1'b1;
        a    = 16'h0000;
        b    = 16'h0000;
        Cin  = 1'b1;
        mode = 1'b0;
        sel  = 4'b0000;

        dv[0]  = '{1'b0, 4'b1001, 16'hFFFF, 16'h0001, 1'b1, 16'h0000, 1'b0};
        dv[1]  = '{1'b0, 4'b1001, 16'hCAFE, 16'hBABE, 1'b0, 16'h85BD, 1'b0};
        dv[2]  = '{1'b0, 4'b1001, 16'h7FFF, 16'h0001, 1'b1, 16'h8000, 1'b1};
        dv[3]  = '{1'b0, 4'b0110, 16'h1234, 16'h1234, 1'b1, 16'hFFFF, 1'b0};
        dv[4]  = '{1'b0, 4'b0110, 16'hFFFF, 16'h0001, 1'b0, 16'hFFFE, 1'b1};
        dv[5]  = '{1'b0, 4'b0110, 16'h0000, 16'h0001, 1'b1, 16'hFFFE, 1'b0};
        dv[6]  = '{1'b0, 4'b1100, 16'hAAAA, 16'h1357, 1'b1, 16'h5554, 1'b0};
        dv[7]  = '{1'b0, 4'b1000, 16'h1234, 16'hFFFF, 1'b1, 16'h2468, 1'b1};
        dv[8]  = '{1'b0, 4'b1000, 16'hAAAA, 16'h5555, 1'b0, 16'hAAAB, 1'b1};
        dv[9]  = '{1'b1, 4'b1011, 16'hCAFE, 16'hBABE, 1'b0, 16'h8ABE, 1'b1};
        dv[10] = '{1'b1, 4'b1011, 16'hCAFE, 16'hBABE, 1'b1, 16'h8ABE, 1'b1};
        dv[11] = '{1'b1, 4'b1110, 16'hC0DE, 16'h00FF, 1'b0, 16'hC0FF, 1'b1};
        dv[12] = '{1'b1, 4'b1110, 16'hC0DE, 16'h00FF, 1'b1, 16'hC0FF, 1'b1};
        dv[13] = '{1'b1, 4'b0110, 16'hDEAD, 16'hBEEF, 1'b0, 16'h6042, 1'b1};
        dv[14] = '{1'b1, 4'b0110, 16'hDEAD, 16'hBEEF, 1'b1, 16'h6042, 1'b1};
        dv[15] = '{1'b1, 4'b0101, 16'h1234, 16'hB0B0, 1'b0, 16'h4F4F, 1'b1};
        dv[16] = '{1'b1, 4'b0101, 16'h1234, 16'hB0B0, 1'b1, 16'h4F4F, 1'b1};

        // Reset with arbitrary operands in flight.
        drive(1'b1, 1'b0, 4'b1001, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b0, "reset");

        // First ADD: outputs must still show reset values until the next edge.
        drive(1'b0, dv[0].m, dv[0].s, dv[0].a, dv[0].b, dv[0].ci, 1'b1, dv[0].res, dv[0].cout, "dv0");
        #1;
        cmp("hold.result", result, 16'h0000);
        cmp("hold.Cout", {15'h0, Cout}, 16'h0001);
        cmp("hold.nBo", {15'h0, nBo}, 16'h0001);
        cmp("hold.nGo", {15'h0, nGo}, 16'h0001);

        for (int i = 1; i < 17; i++) begin
            drive(1'b0, dv[i].m, dv[i].s, dv[i].a, dv[i].b, dv[i].ci,
                  1'b1, dv[i].res, dv[i].cout, $sformatf("dv%0d", i));
        end

        // Back-to-back stream with a reset landing in the middle.
        for (int i = 0; i < 8; i++) begin
            drive_rand(1'b0, $sformatf("b2b%0d", i));
        end
        drive_rand(1'b1, "b2b_rst");
        for (int i = 8; i < 12; i++) begin
            drive_rand(1'b0, $sformatf("b2b%0d", i));
        end

        // Random soak with occasional resets.
        for (int i = 0; i < 400; i++) begin
            drive_rand(1'($urandom_range(0, 31) == 0), $sformatf("rnd%0d", i));
        end

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 5 && sb_q.size() > 0; i++) begin
            @(posedge clk);
            #2;
        end
        if (sb_q.size() > 0) begin
            failures++;
            $display("FAIL drain: %0d responses outstanding, expected 0", sb_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu16_cla.md
Name: alu16_cla

Overview:
- 16-bit registered ALU implementing the full 74181 function set (32 functions: 16 logic, 16 arithmetic) over the whole word.
- Four 4-bit function slices with a 74182-style carry-lookahead unit.
- Carry-in and carry-out are active-low; group propagate/generate outputs are active-low.
- Datapath block between operand registers and the writeback path; single clock domain.

Parameters:
- none (width fixed at 16; four 4-bit slices)

Ports:
- clk     input   1   system clock, all state on rising edge
- rst     input   1   synchronous, active-high reset
- a       input   16  operand A
- b       input   16  operand B
- Cin     input   1   carry-in, active-low (internal carry c0 = ~Cin)
- mode    input   1   0 = arithmetic, 1 = logic
- sel     input   4   function select S3..S0
- result  output  16  registered function result F
- Cout    output  1   registered carry-out, active-low (borrow convention for subtract, see below)
- nBo     output  1   registered group propagate, active-low
- nGo     output  1   registered group generate, active-low

Behaviour:
- Clock and reset: one clock (clk); rst is synchronous, active-high.
- Reset values: when rst is high at a rising edge, result=16'h0000, Cout=1, nBo=1, nGo=1. Reset overrides any operation in flight.
- Latency: 1 cycle. Inputs sampled at edge N appear on outputs after edge N. No handshake; a new operation is accepted every cycle.

Per-bit terms (i = 0..15):
- U_i = A_i | (B_i & S0) | (~B_i & S1)
- V_i = (A_i & B_i & S3) | (A_i & ~B_i & S2)

Logic mode (mode=1):
- F_i = ~(U_i ^ V_i); carry is ignored.
- Examples: sel 1011 = A&B; sel 1110 = A|B; sel 0110 = A^B; sel 0101 = ~B; sel 1111 = A; sel 0000 = ~A; sel 0011 = 0; sel 1100 = all ones.
- Cout=1 in logic mode.

Arithmetic mode (mode=0):
- {c16, F} = U + V + c0, 17-bit; F_i = U_i ^ V_i ^ c_i.
- Carries come from lookahead: g_i = U_i & V_i, p_i = U_i | V_i.
  - 4-bit slice group G/P.
  - 74182 combine: c4 = G0|P0c0; c8 = G1|P1G0|P1P0c0; c12 similarly; c16 from all four slices.
- Key functions: sel 1001 = A plus B plus c0; sel 0110 = A plus ~B plus c0 (= A minus B minus borrow, with borrow-in = Cin); sel 1100 = A plus A plus c0; sel 1000 = A plus (A&B) plus c0.
- Cout = ~c16 for every arithmetic sel except 0110.
- For sel 0110 (subtract), Cout = c16, i.e. Cout is an active-low borrow-out: 0 means the subtraction borrowed.
- Overflow wraps modulo 2^16.

Group outputs:
- nBo = ~(&p[15:0]).
- nGo = ~(16-bit group generate).
- Computed for both modes, from U/V independent of c0.

- X/undefined inputs are not required to be handled.

Test Plan:
- Reset: assert rst for 1 cycle with arbitrary inputs -> result=0000, Cout=1, nBo=1, nGo=1. Deassert, apply ADD; output changes only after the next edge.
- ADD (mode=0, sel=1001): a=FFFF, b=0001, Cin=1 -> result=0000, Cout=0, nBo=0, nGo=0. a=CAFE, b=BABE, Cin=0 -> result=85BD, Cout=0. a=7FFF, b=0001, Cin=1 -> result=8000, Cout=1.
- SUB (mode=0, sel=0110):
  - a=1234, b=1234, Cin=1 -> result=FFFF, Cout=0 (borrow).
  - a=FFFF, b=0001, Cin=0 -> result=FFFE, Cout=1.
  - a=0000, b=0001, Cin=1 -> result=FFFE, Cout=0.
- A+A (sel=1100) and A+(A&B) (sel=1000), mode=0:
  - A+A: a=AAAA, Cin=1 -> result=5554, Cout=0.
  - A+(A&B): a=1234, b=FFFF, Cin=1 -> result=2468, Cout=1.
  - A+(A&B): a=AAAA, b=5555, Cin=0 -> result=AAAB, Cout=1.
- Logic (mode=1), Cin toggled each vector with no effect on result:
  - AND sel=1011: CAFE, BABE -> 8ABE.
  - OR sel=1110: C0DE, 00FF -> C0FF.
  - XOR sel=0110: DEAD, BEEF -> 6042.
  - ~B sel=0101: b=B0B0 -> 4F4F.
- Back-to-back: a different operation every cycle for 8 cycles -> each result appears exactly one cycle after its inputs. Assert rst mid-stream -> the next output is the reset values.
